// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neural network popcount accumulator:
// activation encodings and the accumulator FSM state type.
package tnn_pkg;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Minimum signed accumulator width that can hold NUM_CHUNKS chunks of +/-15.
    function automatic int min_acc_width(input int num_chunks);
        return $clog2(15 * num_chunks + 1) + 1;
    endfunction

endpackage

// File: rtl/tnn_ternary_thresh.sv
// Ternary activation: +1 above thr_hi, -1 below thr_lo, 0 otherwise.
// +1 wins when the thresholds are inverted.
module tnn_ternary_thresh
    import tnn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] sum,
    input  logic signed [W-1:0] thr_hi,
    input  logic signed [W-1:0] thr_lo,
    output logic        [1:0]   act
);

    always_comb begin
        act = ACT_ZERO;
        if (sum > thr_hi) begin
            act = ACT_POS;
        end else if (sum < thr_lo) begin
            act = ACT_NEG;
        end
    end

endmodule

// File: rtl/tnn_popcount_accum.sv
// Accumulates (pos - neg) popcount differences over NUM_CHUNKS chunks per
// neuron, then holds the sum and its ternary activation until consumed.
module tnn_popcount_accum
    import tnn_pkg::*;
#(
    parameter int NUM_CHUNKS = 8,
    parameter int ACC_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [3:0]       in_pos,
    input  logic        [3:0]       in_neg,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic        [1:0]       out_act
);

    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    if (ACC_W < min_acc_width(NUM_CHUNKS)) begin : g_acc_w_check
        $error("tnn_popcount_accum: ACC_W too small for NUM_CHUNKS");
    end

    state_t state_q;
    state_t state_d;

    logic        [CNT_W-1:0] cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] thr_hi_q;
    logic signed [ACC_W-1:0] thr_lo_q;
    logic signed [ACC_W-1:0] out_sum_q;
    logic        [1:0]       out_act_q;

    logic                    accept;
    logic                    first_chunk;
    logic                    last_chunk;
    logic signed [4:0]       chunk_diff;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] thr_hi_eff;
    logic signed [ACC_W-1:0] thr_lo_eff;
    logic        [1:0]       act_next;

    assign accept      = in_valid & in_ready;
    assign first_chunk = (cnt_q == '0);
    assign last_chunk  = (cnt_q == LAST_CNT);

    // Popcounts may reach 15, so the difference needs the full 5-bit signed range.
    assign chunk_diff = $signed({1'b0, in_pos}) - $signed({1'b0, in_neg});
    assign acc_base   = first_chunk ? '0 : acc_q;
    assign acc_sum    = acc_base + ACC_W'(chunk_diff);

    // Bypass the threshold registers on chunk 0 so a one-chunk neuron still
    // classifies against the thresholds presented with it.
    assign thr_hi_eff = first_chunk ? thr_hi : thr_hi_q;
    assign thr_lo_eff = first_chunk ? thr_lo : thr_lo_q;

    tnn_ternary_thresh #(
        .W (ACC_W)
    ) u_thresh (
        .sum    (acc_sum),
        .thr_hi (thr_hi_eff),
        .thr_lo (thr_lo_eff),
        .act    (act_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (accept && last_chunk) state_d = HOLD;
            HOLD:  if (out_ready)            state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            thr_hi_q  <= '0;
            thr_lo_q  <= '0;
            out_sum_q <= '0;
            out_act_q <= ACT_ZERO;
        end else if (accept) begin
            if (first_chunk) begin
                thr_hi_q <= thr_hi;
                thr_lo_q <= thr_lo;
            end
            if (last_chunk) begin
                cnt_q     <= '0;
                acc_q     <= '0;
                out_sum_q <= acc_sum;
                out_act_q <= act_next;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_sum;
            end
        end
    end

    assign out_sum = out_sum_q;
    assign out_act = out_act_q;

endmodule

// File: tb/tb_tnn_popcount_accum.sv
// Self-checking bench for tnn_popcount_accum: directed and random neurons
// checked against a sum-of-differences reference model.
module tb_tnn_popcount_accum;

    localparam int NC    = 8;
    localparam int ACC_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic        [3:0]       in_pos = '0;
    logic        [3:0]       in_neg = '0;
    logic signed [ACC_W-1:0] thr_hi = '0;
    logic signed [ACC_W-1:0] thr_lo = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_sum;
    logic        [1:0]       out_act;

    int checks = 0;
    int errors = 0;

    logic [3:0] chunk_pos [NC];
    logic [3:0] chunk_neg [NC];
    logic signed [ACC_W-1:0] held_sum;
    logic        [1:0]       held_act;

    tnn_popcount_accum #(
        .NUM_CHUNKS (NC),
        .ACC_W      (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_act   (out_act)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] act_of(input int s, input int hi, input int lo);
        if (s > hi) return 2'b01;
        if (s < lo) return 2'b11;
        return 2'b00;
    endfunction

    // Feeds the chunks in chunk_pos/chunk_neg with occasional idle cycles and
    // garbage thresholds after chunk 0, then checks the held result.
    task automatic feed_neuron(input logic signed [ACC_W-1:0] hi, input logic signed [ACC_W-1:0] lo);
        int s;
        logic [1:0] exp_act;
        s = 0;
        for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_pos   = 4'($urandom);
                in_neg   = 4'($urandom);
                thr_hi   = ACC_W'($urandom);
                thr_lo   = ACC_W'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_pos   = chunk_pos[i];
            in_neg   = chunk_neg[i];
            if (i == 0) begin
                thr_hi = hi;
                thr_lo = lo;
            end else begin
                thr_hi = ACC_W'($urandom);
                thr_lo = ACC_W'($urandom);
            end
            check("in_ready_accum", 32'(in_ready), 32'd1);
            check("out_valid_accum", 32'(out_valid), 32'd0);
            s += int'(chunk_pos[i]) - int'(chunk_neg[i]);
            step();
        end
        in_valid = 1'b0;
        exp_act  = act_of(s, int'(hi), int'(lo));
        check("out_valid_latency1", 32'(out_valid), 32'd1);
        check("in_ready_hold", 32'(in_ready), 32'd0);
        check("out_sum", 32'(out_sum), 32'(ACC_W'(s)));
        check("out_act", 32'(out_act), 32'(exp_act));
        held_sum = out_sum;
        held_act = out_act;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_consumed", 32'(out_valid), 32'd0);
        check("in_ready_after_consume", 32'(in_ready), 32'd1);
    endtask

    task automatic fill_const(input logic [3:0] p, input logic [3:0] n);
        for (int i = 0; i < NC; i++) begin
            chunk_pos[i] = p;
            chunk_neg[i] = n;
        end
    endtask

    initial begin
        $display("[TB] start");
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_act", 32'(out_act), 32'd0);
        check("post_rst_out_sum", 32'(out_sum), 32'd0);

        fill_const(4'd12, 4'd0);
        feed_neuron(8'sd50, -8'sd50);
        consume();

        fill_const(4'd0, 4'd15);
        feed_neuron(8'sd0, 8'sd0);
        consume();

        // sum of exactly 10 at the threshold boundaries
        fill_const(4'd0, 4'd0);
        for (int i = 0; i < 5; i++) chunk_pos[i] = 4'd2;
        feed_neuron(8'sd10, -8'sd10);
        consume();
        feed_neuron(8'sd5, 8'sd20);
        consume();
        feed_neuron(8'sd40, 8'sd10);
        consume();
        feed_neuron(8'sd40, 8'sd11);
        consume();

        // backpressure with in_valid asserted throughout
        fill_const(4'd3, 4'd1);
        feed_neuron(8'sd20, -8'sd20);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_pos   = 4'($urandom);
            in_neg   = 4'($urandom);
            step();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum_stable", 32'(out_sum), 32'(held_sum));
            check("bp_out_act_stable", 32'(out_act), 32'(held_act));
        end
        in_pos = 4'd15;
        consume();
        in_valid = 1'b0;
        fill_const(4'd1, 4'd2);
        feed_neuron(8'sd0, -8'sd9);
        consume();

        // asynchronous reset mid-neuron discards the partial sum
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pos   = 4'd5;
            in_neg   = 4'd0;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        fill_const(4'd1, 4'd0);
        feed_neuron(8'sd3, -8'sd3);
        consume();

        // reset in HOLD drops the pending result
        fill_const(4'd9, 4'd2);
        feed_neuron(8'sd1, 8'sd0);
        rst_n = 1'b0;
        #1;
        check("hold_rst_out_valid", 32'(out_valid), 32'd0);
        check("hold_rst_out_sum", 32'(out_sum), 32'd0);
        check("hold_rst_out_act", 32'(out_act), 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        repeat (3) begin
            step();
            check("no_pulse_after_rst", 32'(out_valid), 32'd0);
        end

        // random neurons
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NC; i++) begin
                chunk_pos[i] = 4'($urandom);
                chunk_neg[i] = 4'($urandom);
            end
            feed_neuron(ACC_W'($urandom_range(0, 255)), ACC_W'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) step();
            consume();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tnn_popcount_accum.md
TNN_POPCOUNT_ACCUM -- requirements
Module: tnn_popcount_accum

Interface
REQ-001 The block SHALL have parameter NUM_CHUNKS, default 8, giving the number of 12-input chunks per neuron.
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the signed accumulator width; it SHALL satisfy ACC_W >= clog2(15*NUM_CHUNKS+1)+1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: a chunk is presented.
REQ-007 Port in_ready, output, 1 bit: the block accepts a chunk this cycle.
REQ-008 Port in_pos, input, 4 bits, unsigned: popcount of positive-weight matches for the chunk, from the 12-input popcount stage.
REQ-009 Port in_neg, input, 4 bits, unsigned: popcount of negative-weight matches for the chunk.
REQ-010 Port thr_hi, input, ACC_W bits, signed: upper activation threshold.
REQ-011 Port thr_lo, input, ACC_W bits, signed: lower activation threshold.
REQ-012 Port out_valid, output, 1 bit: a neuron result is held.
REQ-013 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 Port out_sum, output, ACC_W bits, signed: final accumulated sum.
REQ-015 Port out_act, output, 2 bits: ternary activation; 2'b01 = +1, 2'b00 = 0, 2'b11 = -1.

Function
REQ-016 A chunk SHALL be accepted on a cycle with in_valid=1 and in_ready=1 (transfer).
REQ-017 The FSM SHALL have two states, ACCUM and HOLD.
- ACCUM: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-018 In ACCUM, each transfer SHALL perform acc <= acc + (in_pos - in_neg) and cnt <= cnt + 1. The difference SHALL be sign-extended to ACC_W; there SHALL be no saturation, since the REQ-002 width rule guarantees no overflow.
REQ-019 On the transfer of chunk 0 (cnt == 0), the block SHALL start from acc = 0 and register thr_hi and thr_lo. Thresholds SHALL be ignored at all other times.
REQ-020 On the transfer with cnt == NUM_CHUNKS-1, the block SHALL:
- register out_sum = final sum;
- register out_act using the registered thresholds;
- clear cnt;
- enter HOLD.
out_valid SHALL rise on the cycle immediately after that transfer (latency 1).
REQ-021 Activation SHALL be:
- +1 if sum > thr_hi;
- else -1 if sum < thr_lo;
- else 0.
Comparisons SHALL be signed and strict, and +1 SHALL take priority when thr_lo > thr_hi.
REQ-022 In HOLD, out_sum and out_act SHALL remain stable until out_ready=1. On that cycle the result SHALL be consumed and the FSM SHALL return to ACCUM, so in_ready=1 on the next cycle.
REQ-023 In HOLD, in_valid SHALL be ignored, and no chunk SHALL be lost because in_ready=0.
REQ-024 Cycles in ACCUM with in_valid=0 SHALL leave acc and cnt unchanged.
REQ-025 in_pos and in_neg values up to 15 SHALL be handled arithmetically; no range check SHALL be applied (the approximate popcount may exceed 12).

Reset
REQ-026 While rst_n=0, the block SHALL hold: state=ACCUM, acc=0, cnt=0, thresholds=0, out_valid=0, out_sum=0, out_act=2'b00, in_ready=1.
REQ-027 Reset asserted mid-neuron or in HOLD SHALL discard the partial sum or the pending result, with no output pulse.

Structure
REQ-028 Package tnn_pkg SHALL hold:
- the activation encoding constants ACT_POS, ACT_ZERO, ACT_NEG;
- the FSM state enum.
REQ-029 Combinational sub-module tnn_ternary_thresh SHALL implement REQ-021 (sum, thr_hi, thr_lo -> act).
REQ-030 cnt SHALL be clog2(NUM_CHUNKS) bits and SHALL wrap only via the explicit clear in REQ-020.

Verification (NUM_CHUNKS=8, ACC_W=8)
REQ-031 Reset: after rst_n release, out_valid=0, in_ready=1, out_act=00, out_sum=0.
REQ-032 8 transfers with in_pos=12, in_neg=0, thr_hi=50, thr_lo=-50 -> out_sum=96, out_act=01, out_valid high exactly 1 cycle after the 8th transfer.
REQ-033 8 transfers with in_pos=0, in_neg=15, thr_hi=0, thr_lo=0 -> out_sum=-120, out_act=11.
REQ-034 Boundary: sum exactly 10 with thr_hi=10, thr_lo=-10 -> out_act=00; a repeat with thr_lo=20, thr_hi=5 and sum 10 -> out_act=01.
REQ-035 Backpressure: result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> in_ready=1 next cycle, and the next 8 chunks start from acc=0.
REQ-036 Reset mid-operation: reset after 3 transfers, then 8 transfers of pos=1, neg=0 -> out_sum=8, with no extra out_valid pulse.
